dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/DMA loader).
- Grants at most one access per cycle using round-robin with a burst cap.
- Forwards the winning request to memory and routes read data back to the issuing port after a fixed latency.
- A CPU with no grant stalls; the arbiter never drops or reorders accepted requests.

Parameters:
- AW, 64, address width.
- DW, 64, data width.
- RD_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid RD_LAT cycles after mem_en && !mem_we.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (>=1).

Ports:
- clk, in, 1, clock; all state on rising edge.
- rst, in, 1, reset; asynchronous assert, active-low (0 = reset).
- req0 / req1, in, 1, access request from port 0 / port 1.
- we0 / we1, in, 1, 1 = write, 0 = read.
- addr0 / addr1, in, AW, byte address.
- wdata0 / wdata1, in, DW, write data.
- gnt0 / gnt1, out, 1, combinational grant. A request is accepted in a cycle where req && gnt.
- rvalid0 / rvalid1, out, 1, read data valid for port 0 / port 1.
- rdata0 / rdata1, out, DW, read data; equals mem_rdata when the matching rvalid is high, else 0.
- mem_en, out, 1, memory access this cycle.
- mem_we, out, 1, memory write.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data.

Behaviour:
- Reset (rst=0, async):
  - last_gnt <= 1, so port 0 wins the first tie.
  - burst_cnt <= 0.
  - Read-tracking pipeline cleared, so in-flight reads never produce rvalid.
  - All outputs are 0 while rst=0; gnt is forced 0.
- Grant (combinational):
  - Only one port requesting: that port is granted.
  - Both requesting: the port != last_gnt is granted, unless last_gnt's burst is still active (see burst rule).
  - Neither requesting: no grant; mem_en=0.
- Burst rule:
  - burst_cnt counts consecutive grants to last_gnt.
  - Both requesting and burst_cnt < MAX_BURST: last_gnt keeps the grant.
  - Both requesting and burst_cnt == MAX_BURST: grant switches to the other port.
  - On a switch, burst_cnt <= 1. On a repeat grant, burst_cnt <= min(burst_cnt+1, MAX_BURST).
  - Idle cycles leave last_gnt and burst_cnt unchanged.
  - With MAX_BURST=1 this reduces to strict alternation under contention.
- Memory side:
  - mem_en = gnt0|gnt1.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port; all 0 when idle.
- Read return:
  - Shift register of depth RD_LAT carries {valid, port_id} for each granted read.
  - At the tail, the entry raises rvalid of port_id for exactly one cycle with mem_rdata.
  - Back-to-back reads from alternating ports return in issue order, one per cycle, no bubbles.
- Writes:
  - Complete on the grant cycle; no rvalid is generated.
- Requester rules:
  - Requesters hold req/we/addr/wdata stable until granted.
  - Dropping req before grant is legal and simply withdraws the request.
- Simultaneous events: a new grant in the same cycle as an rvalid return is allowed; the ports are independent.

Test Plan:
- Reset then single port: rst 0->1; req0=1, we0=0, addr0=0x40; mem returns 0xDEAD after 1 cycle -> gnt0=1 at cycle 0, mem_addr=0x40, rvalid0=1 with rdata0=0xDEAD at cycle 1, rvalid1=0.
- First tie: req0=req1=1 right after reset -> gnt0 in the first cycle; with MAX_BURST=4, grants go 0,0,0,0,1,1,1,1,0.
- MAX_BURST=1 alternation: both request reads for 6 cycles -> grants 0,1,0,1,0,1; rvalid0/rvalid1 alternate starting one cycle later with matching data.
- Write then read: port 1 writes 0x1234 to 0x80, then port 0 reads 0x80 -> mem_we=1 in cycle 0, rvalid0 with 0x1234 in cycle 2, no rvalid1.
- Reset mid-read: grant a read to port 1, then drop rst to 0 before its return cycle -> rvalid1 stays 0 and all outputs are 0; after release, port 0 wins the first tie.
- Idle preserves state: port 0 granted twice, 3 idle cycles, then both request with MAX_BURST=4 -> port 0 is granted twice more (burst_cnt resumes at 2), then port 1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin with a burst
// cap, memory request muxing, and fixed-latency read data return routing.
module dmem_arbiter #(
  parameter int unsigned AW        = 64,
  parameter int unsigned DW        = 64,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_ONE = CW'(1);

  logic              last_gnt_q, last_gnt_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0] rd_port_q, rd_port_d;

  logic keep_last;
  logic pick1;
  logic new_rd;
  logic tail_vld;
  logic tail_port;

  // A zero count means no burst is running, so a tie goes to the other port.
  always_comb begin
    keep_last = (burst_cnt_q != '0) && (burst_cnt_q < BURST_MAX);
    pick1     = keep_last ? last_gnt_q : ~last_gnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        gnt0 = ~pick1;
        gnt1 = pick1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    if (mem_en) begin
      if (gnt1 == last_gnt_q) begin
        if (burst_cnt_q != BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + BURST_ONE;
        end
      end else begin
        last_gnt_d  = gnt1;
        burst_cnt_d = BURST_ONE;
      end
    end
  end

  // Each granted read enters at bit 0 and surfaces at the top bit RD_LAT cycles later.
  always_comb begin
    new_rd    = mem_en && !mem_we;
    rd_vld_d  = (rd_vld_q << 1) | RD_LAT'(new_rd);
    rd_port_d = (rd_port_q << 1) | RD_LAT'(new_rd && gnt1);
    tail_vld  = rd_vld_q[RD_LAT-1];
    tail_port = rd_port_q[RD_LAT-1];
  end

  always_comb begin
    rvalid0 = rst && tail_vld && !tail_port;
    rvalid1 = rst && tail_vld && tail_port;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rd_vld_q    <= '0;
      rd_port_q   <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_port_q   <= rd_port_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three configurations share one stimulus stream, each
// checked every cycle against a transaction-level model, plus literal checks.
module tb_dmem_arbiter;

  localparam int NI = 3;

  typedef struct {
    int          due;
    logic        port;
    logic [63:0] data;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic [NI-1:0] gnt0_w, gnt1_w, rv0_w, rv1_w, men_w, mwe_w;
  logic [63:0]   rd0_w [NI];
  logic [63:0]   rd1_w [NI];
  logic [63:0]   maddr_w [NI];
  logic [63:0]   mwd_w [NI];
  logic [63:0]   mrd_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Power-up memory contents; word 8 (byte 0x40) holds 0xDEAD.
  function automatic logic [63:0] init_word(input logic [7:0] k);
    if (k == 8'd8) return 64'hDEAD;
    return 64'h1111_0000_0000_0000 | (64'(k) * 64'h101);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int unsigned MB = (gi == 0) ? 4 : (gi == 1) ? 1 : 2;
    localparam int unsigned RL = (gi == 2) ? 3 : 1;

    dmem_arbiter #(.AW(64), .DW(64), .RD_LAT(RL), .MAX_BURST(MB)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_w[gi]), .gnt1(gnt1_w[gi]),
      .rvalid0(rv0_w[gi]), .rvalid1(rv1_w[gi]),
      .rdata0(rd0_w[gi]), .rdata1(rd1_w[gi]),
      .mem_en(men_w[gi]), .mem_we(mwe_w[gi]),
      .mem_addr(maddr_w[gi]), .mem_wdata(mwd_w[gi]),
      .mem_rdata(mrd_w[gi])
    );

    // Memory behind the DUT; the return pipe carries junk on non-read cycles.
    logic [63:0]  mem [256];
    logic [255:0] wr_mask = '0;
    logic [63:0]  pipe [RL];
    logic [63:0]  junk = 64'hBAD0_0000_0000_0000;

    function automatic logic [63:0] mem_rd(input logic [7:0] k);
      return wr_mask[k] ? mem[k] : init_word(k);
    endfunction

    assign mrd_w[gi] = pipe[RL-1];

    always @(posedge clk) begin
      junk    <= junk + 64'd1;
      pipe[0] <= (men_w[gi] && !mwe_w[gi]) ? mem_rd(maddr_w[gi][10:3]) : junk;
      for (int k = 1; k < int'(RL); k++) pipe[k] <= pipe[k-1];
      if (men_w[gi] && mwe_w[gi]) begin
        mem[maddr_w[gi][10:3]]     <= mwd_w[gi];
        wr_mask[maddr_w[gi][10:3]] <= 1'b1;
      end
    end

    initial begin : model
      ret_t         q[$];
      ret_t         r;
      logic [63:0]  sh [256];
      logic [255:0] sh_m;
      int           cyc, last, run, win;
      logic         e_rv0, e_rv1, e_we;
      logic [63:0]  e_rd0, e_rd1, e_addr, e_wd;
      logic [7:0]   k;
      string        p;
      cyc  = 0;
      last = 1;
      run  = 0;
      sh_m = '0;
      p = $sformatf("i%0d_", gi);
      forever begin
        @(negedge clk);
        #2;
        win = -1;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (!rst) begin
          q.delete();
          last = 1;
          run  = 0;
        end else begin
          if (req0 && req1) win = (run == 0 || run >= int'(MB)) ? 1 - last : last;
          else if (req0) win = 0;
          else if (req1) win = 1;
          if (win == 0) begin e_we = we0; e_addr = addr0; e_wd = wdata0; end
          if (win == 1) begin e_we = we1; e_addr = addr1; e_wd = wdata1; end
          if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.port) begin e_rv1 = 1'b1; e_rd1 = r.data; end
            else        begin e_rv0 = 1'b1; e_rd0 = r.data; end
          end
        end
        chk({p, "gnt0"},    64'(gnt0_w[gi]), 64'(win == 0));
        chk({p, "gnt1"},    64'(gnt1_w[gi]), 64'(win == 1));
        chk({p, "mem_en"},  64'(men_w[gi]),  64'(win >= 0));
        chk({p, "mem_we"},  64'(mwe_w[gi]),  64'(e_we));
        chk({p, "mem_addr"}, maddr_w[gi], e_addr);
        chk({p, "mem_wdata"}, mwd_w[gi], e_wd);
        chk({p, "rvalid0"}, 64'(rv0_w[gi]), 64'(e_rv0));
        chk({p, "rvalid1"}, 64'(rv1_w[gi]), 64'(e_rv1));
        chk({p, "rdata0"},  rd0_w[gi], e_rd0);
        chk({p, "rdata1"},  rd1_w[gi], e_rd1);
        if (win >= 0) begin
          k = e_addr[10:3];
          if (e_we) begin
            sh[k] = e_wd;
            sh_m[k] = 1'b1;
          end else begin
            r.due  = cyc + int'(RL);
            r.port = (win == 1);
            r.data = sh_m[k] ? sh[k] : init_word(k);
            q.push_back(r);
          end
          if (win == last) begin
            if (run < int'(MB)) run++;
          end else begin
            last = win;
            run  = 1;
          end
        end
        cyc++;
      end
    end
  end

  task automatic set(input logic r0, input logic w0, input logic [63:0] a0, input logic [63:0] d0,
                     input logic r1, input logic w1, input logic [63:0] a1, input logic [63:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    logic [8:0] seq0, alt0, arv0, arv1;
    logic [2:0] idle_seq;
    logic [63:0] alt_d0, alt_d1;
    seq0 = '0; alt0 = '0; arv0 = '0; arv1 = '0; idle_seq = '0;
    alt_d0 = '0; alt_d1 = '0;

    // Outputs stay 0 in reset even with a request pending.
    rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    set(1, 0, 64'h40, 0, 0, 0, 0, 0);
    #3;
    chk("rst_gnt0", 64'(gnt0_w[0]), 0);
    chk("rst_mem_en", 64'(men_w[0]), 0);
    chk("rst_mem_addr", maddr_w[0], 0);

    // Single read from port 0.
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("single_gnt0", 64'(gnt0_w[0]), 1);
    chk("single_mem_addr", maddr_w[0], 64'h40);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("single_rvalid0", 64'(rv0_w[0]), 1);
    chk("single_rdata0", rd0_w[0], 64'hDEAD);
    chk("single_rvalid1", 64'(rv1_w[0]), 0);

    // Continuous contention right after reset.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    set(1, 0, 64'h100, 0, 1, 0, 64'h200, 0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      seq0[c] = gnt0_w[0];
      alt0[c] = gnt0_w[1];
      arv0[c] = rv0_w[1];
      arv1[c] = rv1_w[1];
      if (c == 1) alt_d0 = rd0_w[1];
      if (c == 2) alt_d1 = rd1_w[1];
    end
    chk("burst4_gnt0_seq", 64'(seq0), 64'(9'b1_0000_1111));
    chk("burst1_gnt0_seq", 64'(alt0), 64'(9'b1_0101_0101));
    chk("burst1_rvalid0_seq", 64'(arv0), 64'(9'b0_1010_1010));
    chk("burst1_rvalid1_seq", 64'(arv1), 64'(9'b1_0101_0100));
    chk("burst1_rdata0", alt_d0, 64'h1111_0000_0000_2020);
    chk("burst1_rdata1", alt_d1, 64'h1111_0000_0000_4040);

    // Port 1 writes, port 0 reads the same word back.
    @(negedge clk); rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    set(0, 0, 0, 0, 1, 1, 64'h80, 64'h1234);
    #3;
    chk("wr_gnt1", 64'(gnt1_w[0]), 1);
    chk("wr_mem_we", 64'(mwe_w[0]), 1);
    chk("wr_mem_wdata", mwd_w[0], 64'h1234);
    @(negedge clk);
    set(1, 0, 64'h80, 0, 0, 0, 0, 0);
    #3;
    chk("rd_gnt0", 64'(gnt0_w[0]), 1);
    chk("rd_rvalid1", 64'(rv1_w[0]), 0);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rd_rvalid0", 64'(rv0_w[0]), 1);
    chk("rd_rdata0", rd0_w[0], 64'h1234);
    chk("rd_no_rvalid1", 64'(rv1_w[0]), 0);

    // Reset while a port 1 read is in flight.
    @(negedge clk);
    set(0, 0, 0, 0, 1, 0, 64'h300, 0);
    #3;
    chk("mid_gnt1", 64'(gnt1_w[2]), 1);
    @(negedge clk); rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("mid_rvalid1", 64'(rv1_w[0]), 0);
    chk("mid_rdata1", rd1_w[0], 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    set(1, 0, 64'h100, 0, 1, 0, 64'h200, 0);
    #3;
    chk("mid_tie_gnt0", 64'(gnt0_w[0]), 1);
    chk("mid_lat3_rvalid1", 64'(rv1_w[2]), 0);

    // Idle cycles keep the running burst count.
    @(negedge clk); rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    set(1, 0, 64'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    set(1, 0, 64'h40, 0, 1, 0, 64'h48, 0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      idle_seq[c] = gnt0_w[0];
    end
    chk("idle_gnt0_seq", 64'(idle_seq), 64'(3'b011));

    // Mixed traffic, rare resets; the per-cycle model does the checking.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) != 0);
      set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {$urandom, 21'($urandom), 3'b000}, {$urandom, $urandom},
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {$urandom, 21'($urandom), 3'b000}, {$urandom, $urandom});
    end

    @(negedge clk);
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
